// File: rtl/serial_alu_pkg.sv
// Shared types for the digit-serial ALU: operation encodings and FSM states.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_NOR  = 2'b01,
        OP_ADD  = 2'b10,
        OP_SHR  = 2'b11
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/serial_alu_n_if.sv
// Start/busy/done handshake plus operand and result bus of the serial ALU.
interface serial_alu_n_if #(
    parameter int WIDTH = 16
);
    import serial_alu_pkg::*;

    logic             start;
    alu_op_t          op;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] x;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;

    modport master (
        output start, op, cin, a, x,
        input  busy, done, result, cout, zero
    );

    modport slave (
        input  start, op, cin, a, x,
        output busy, done, result, cout, zero
    );

endinterface

// File: rtl/serial_alu_slice.sv
// Combinational DIGIT-bit ALU slice built from a chain of 1-bit cells.
module serial_alu_slice
    import serial_alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] x_d,
    input  logic             x_la,
    input  logic             c_in,
    input  alu_op_t          op,
    output logic [DIGIT-1:0] r_d,
    output logic             c_out
);

    // Returns {carry_out, result_bit}; only ADD modifies the carry, the rest pass it through.
    function automatic logic [1:0] alu_cell(input alu_op_t f, input logic ab, input logic xb,
                                            input logic xn, input logic ci);
        logic [1:0] res;
        case (f)
            OP_PASS: res = {ci, xb};
            OP_NOR:  res = {ci, ~(ab | xb)};
            OP_ADD:  res = {(ab & xb) | (ci & (ab ^ xb)), ab ^ xb ^ ci};
            default: res = {ci, xn};
        endcase
        return res;
    endfunction

    logic [DIGIT:0] c;
    logic [DIGIT:0] xe;

    assign c[0] = c_in;
    assign xe   = {x_la, x_d};

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign {c[i+1], r_d[i]} = alu_cell(op, a_d[i], xe[i], xe[i+1], c[i]);
    end

    assign c_out = c[DIGIT];

endmodule

// File: rtl/serial_alu_n.sv
// Digit-serial ALU: WIDTH-bit operation processed LSB-first, DIGIT bits per clock.
module serial_alu_n
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input logic           clk,
    input logic           rst_n,
    serial_alu_n_if.slave bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N + 1);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_alu_n: WIDTH must be a non-zero multiple of DIGIT");
    end

    alu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sr, x_sr, r_sr;
    alu_op_t          op_q;
    logic             cin_q;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             zero_q;
    logic             done_q;

    logic             load;
    logic             step;
    logic             last;
    logic             x_la;
    logic [DIGIT-1:0] r_d;
    logic             slice_c;
    logic             carry_d;
    logic [WIDTH-1:0] r_next;

    assign last = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // The shift-right look-ahead bit comes from the next digit, or from cin on the final digit.
    if (DIGIT < WIDTH) begin : g_la
        assign x_la = last ? cin_q : x_sr[DIGIT];
    end else begin : g_la_full
        assign x_la = cin_q;
    end

    serial_alu_slice #(.DIGIT(DIGIT)) u_slice (
        .a_d   (a_sr[DIGIT-1:0]),
        .x_d   (x_sr[DIGIT-1:0]),
        .x_la  (x_la),
        .c_in  (carry_q),
        .op    (op_q),
        .r_d   (r_d),
        .c_out (slice_c)
    );

    // SHR shifts out x[0]; it is captured on the first digit and then carried through unchanged.
    assign carry_d = (op_q == OP_SHR && cnt_q == '0) ? x_sr[0] : slice_c;
    assign r_next  = (r_sr >> DIGIT) | (WIDTH'(r_d) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            x_sr     <= '0;
            r_sr     <= '0;
            op_q     <= OP_PASS;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= step & last;
            if (load) begin
                a_sr    <= bus.a;
                x_sr    <= bus.x;
                r_sr    <= '0;
                op_q    <= bus.op;
                cin_q   <= bus.cin;
                carry_q <= bus.cin;
                cnt_q   <= '0;
            end else if (step) begin
                a_sr    <= a_sr >> DIGIT;
                x_sr    <= x_sr >> DIGIT;
                r_sr    <= r_next;
                carry_q <= carry_d;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last) begin
                    result_q <= r_next;
                    cout_q   <= carry_d;
                    zero_q   <= (r_next == '0);
                end
            end
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_serial_alu_n.sv
// Scoreboard bench for serial_alu_n with DIGIT = 1, 2, 4 and 16 instances side by side.
module tb_serial_alu_n;
    import serial_alu_pkg::*;

    typedef struct {
        logic [15:0] r;
        logic        co;
        logic        z;
        int          e0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int compared = 0;
    int mismatched = 0;

    logic        start_c;
    alu_op_t     op_c;
    logic        cin_c;
    logic [15:0] a_c, x_c;
    logic [3:0]  sel;

    exp_t q0[$], q1[$], q2[$], q3[$];

    serial_alu_n_if #(.WIDTH(16)) if1 ();
    serial_alu_n_if #(.WIDTH(16)) if2 ();
    serial_alu_n_if #(.WIDTH(16)) if4 ();
    serial_alu_n_if #(.WIDTH(16)) if16 ();

    assign if1.start  = start_c & sel[0];
    assign if2.start  = start_c & sel[1];
    assign if4.start  = start_c & sel[2];
    assign if16.start = start_c & sel[3];
    assign if1.op = op_c;   assign if2.op = op_c;   assign if4.op = op_c;   assign if16.op = op_c;
    assign if1.cin = cin_c; assign if2.cin = cin_c; assign if4.cin = cin_c; assign if16.cin = cin_c;
    assign if1.a = a_c;     assign if2.a = a_c;     assign if4.a = a_c;     assign if16.a = a_c;
    assign if1.x = x_c;     assign if2.x = x_c;     assign if4.x = x_c;     assign if16.x = x_c;

    serial_alu_n #(.WIDTH(16), .DIGIT(1))  u_d1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_alu_n #(.WIDTH(16), .DIGIT(2))  u_d2  (.clk(clk), .rst_n(rst_n), .bus(if2));
    serial_alu_n #(.WIDTH(16), .DIGIT(4))  u_d4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_alu_n #(.WIDTH(16), .DIGIT(16)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic co, input logic z);
        exp_t e;
        e.r = r; e.co = co; e.z = z; e.e0 = 0;
        return e;
    endfunction

    function automatic exp_t model(input alu_op_t op, input logic ci,
                                   input logic [15:0] a, input logic [15:0] x);
        logic [16:0] s;
        logic [15:0] r;
        logic        co;
        case (op)
            OP_PASS: begin r = x;        co = ci;   end
            OP_NOR:  begin r = ~(a | x); co = ci;   end
            OP_ADD:  begin s = {1'b0, a} + {1'b0, x} + {16'd0, ci}; r = s[15:0]; co = s[16]; end
            default: begin r = {ci, x[15:1]}; co = x[0]; end
        endcase
        return mk(r, co, r == 16'd0);
    endfunction

    task automatic on_done(input int k, input int n, input logic [15:0] r,
                           input logic co, input logic z);
        exp_t e;
        logic have;
        have = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        chk($sformatf("u%0d_done_expected", k), 32'(have), 32'd1);
        if (have) begin
            chk($sformatf("u%0d_result", k), 32'(r), 32'(e.r));
            chk($sformatf("u%0d_cout", k), 32'(co), 32'(e.co));
            chk($sformatf("u%0d_zero", k), 32'(z), 32'(e.z));
            chk($sformatf("u%0d_latency", k), 32'(cyc - e.e0), 32'(n));
        end
    endtask

    always @(negedge clk) if (if1.done === 1'b1)  on_done(0, 16, if1.result,  if1.cout,  if1.zero);
    always @(negedge clk) if (if2.done === 1'b1)  on_done(1, 8,  if2.result,  if2.cout,  if2.zero);
    always @(negedge clk) if (if4.done === 1'b1)  on_done(2, 4,  if4.result,  if4.cout,  if4.zero);
    always @(negedge clk) if (if16.done === 1'b1) on_done(3, 1,  if16.result, if16.cout, if16.zero);

    // Called after a negedge; returns 1 time unit after the start edge.
    task automatic go(input logic [3:0] m, input alu_op_t op, input logic ci,
                      input logic [15:0] a, input logic [15:0] x, input exp_t ex, input bit push);
        sel = m; op_c = op; cin_c = ci; a_c = a; x_c = x; start_c = 1'b1;
        ex.e0 = cyc + 1;
        if (push) begin
            if (m[0]) q0.push_back(ex);
            if (m[1]) q1.push_back(ex);
            if (m[2]) q2.push_back(ex);
            if (m[3]) q3.push_back(ex);
        end
        @(posedge clk);
        #1 start_c = 1'b0;
    endtask

    task automatic wait_all_idle(input int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((if1.busy | if2.busy | if4.busy | if16.busy) && t < budget);
        chk("idle_timeout", 32'(if1.busy | if2.busy | if4.busy | if16.busy), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},   32'(if1.busy),   32'd0);
        chk({tag, "_done"},   32'(if1.done),   32'd0);
        chk({tag, "_result"}, 32'(if1.result), 32'd0);
        chk({tag, "_cout"},   32'(if1.cout),   32'd0);
        chk({tag, "_zero"},   32'(if1.zero),   32'd0);
    endtask

    initial begin
        alu_op_t     rop;
        logic        rci;
        logic [15:0] ra, rx;

        // Reset with random inputs applied.
        rst_n = 1'b0; sel = 4'hF; start_c = 1'($urandom);
        op_c = alu_op_t'($urandom_range(0, 3)); cin_c = 1'($urandom);
        a_c = 16'($urandom); x_c = 16'($urandom);
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset_d1");
        chk("reset_d4_busy",   32'(if4.busy),   32'd0);
        chk("reset_d4_result", 32'(if4.result), 32'd0);
        chk("reset_d16_done",  32'(if16.done),  32'd0);
        start_c = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // ADD carry through every bit to a zero result.
        go(4'b0001, OP_ADD, 1'b0, 16'hFFFF, 16'h0001, mk(16'h0000, 1'b1, 1'b1), 1);
        chk("add_busy_after_start", 32'(if1.busy), 32'd1);
        wait_all_idle(40);

        // NOR with cin passed to cout.
        @(negedge clk);
        go(4'b0001, OP_NOR, 1'b1, 16'h00F0, 16'h0F00, mk(16'hF00F, 1'b1, 1'b0), 1);
        wait_all_idle(40);

        // SHR, then a PASS started in the done cycle.
        @(negedge clk);
        go(4'b0001, OP_SHR, 1'b1, 16'h0000, 16'h8001, mk(16'hC000, 1'b1, 1'b0), 1);
        wait_all_idle(40);
        go(4'b0001, OP_PASS, 1'b0, 16'hAAAA, 16'h1234, mk(16'h1234, 1'b0, 1'b0), 1);
        wait_all_idle(40);

        // A start mid-operation must be ignored.
        @(negedge clk);
        go(4'b0001, OP_ADD, 1'b0, 16'h0001, 16'h0001, mk(16'h0002, 1'b0, 1'b0), 1);
        repeat (3) @(negedge clk);
        go(4'b0001, OP_NOR, 1'b1, 16'hFFFF, 16'hFFFF, mk(16'h0000, 1'b1, 1'b1), 0);
        chk("ignored_start_busy", 32'(if1.busy), 32'd1);
        wait_all_idle(40);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        go(4'b0001, OP_ADD, 1'b0, 16'h1234, 16'h1111, mk(16'h2345, 1'b0, 1'b0), 1);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("abort");
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_still_idle", 32'(if1.busy), 32'd0);
        chk("abort_result_kept_zero", 32'(if1.result), 32'd0);

        // DIGIT=4 addition.
        go(4'b0100, OP_ADD, 1'b1, 16'h1234, 16'h0FFF, mk(16'h2234, 1'b0, 1'b0), 1);
        wait_all_idle(40);

        // Random operations on all four digit widths against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = alu_op_t'($urandom_range(0, 3));
            rci = 1'($urandom);
            ra  = (i % 8 == 0) ? 16'hFFFF : 16'($urandom);
            rx  = (i % 8 == 1) ? 16'h0000 : 16'($urandom);
            go(4'hF, rop, rci, ra, rx, model(rop, rci, ra, rx), 1);
            wait_all_idle(40);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
